wb_queue: RTL and testbench

Two-lane writeback serializer between the superscalar pipeline's two result lanes and the single write port of `reg_file` (`rw`, `we`, `inW`). It accepts up to two retired results per cycle in program order, buffers them in a small in-order queue, and drains exactly one per cycle into the register file. It also provides a bypass lookup so the decode stage can read values that are queued but not yet written.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/wb_lookup.sv | 34 +++
 rtl/wb_queue.sv | 83 ++++++++
 tb/tb_wb_queue.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types: register-file geometry and the writeback queue entry.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Priority CAM over the output register and queue entries; youngest match wins.
module wb_lookup
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [REG_ADDR_W-1:0]   addr,
    input  logic                    outValid,
    input  logic [REG_ADDR_W-1:0]   outRd,
    input  logic [DATA_W-1:0]       outData,
    input  wb_entry_t [DEPTH-1:0]   entries,
    output logic                    hit,
    output logic [DATA_W-1:0]       data
);

    // Later assignments override earlier ones, so scan oldest to youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (addr != '0) begin
            if (outValid && outRd == addr) begin
                hit  = 1'b1;
                data = outData;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entries[i].valid && entries[i].rd == addr) begin
                    hit  = 1'b1;
                    data = entries[i].data;
                end
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Two-lane writeback serializer feeding the single reg_file write port, with bypass lookup.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  v0,
    input  logic [REG_ADDR_W-1:0] rd0,
    input  logic [DATA_W-1:0]     d0,
    input  logic                  v1,
    input  logic [REG_ADDR_W-1:0] rd1,
    input  logic [DATA_W-1:0]     d1,
    output logic                  stall,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] rw,
    output logic [DATA_W-1:0]     inW,
    input  logic [REG_ADDR_W-1:0] qa,
    input  logic [REG_ADDR_W-1:0] qb,
    output logic                  hitA,
    output logic                  hitB,
    output logic [DATA_W-1:0]     fwdA,
    output logic [DATA_W-1:0]     fwdB,
    output logic                  empty
);

    localparam int CW = $clog2(DEPTH + 3);

    wb_entry_t [DEPTH-1:0] queue, queueNext;
    wb_entry_t [DEPTH+1:0] cand;
    logic [CW-1:0]         count, countNext, slot1, total;
    logic                  lane0Ok, lane1Ok, loadOut;

    assign stall = (count >= CW'(DEPTH - 1));
    assign empty = (count == '0) && !we;

    // Slots past count are kept all-zero, so lanes simply overwrite their slot.
    always_comb begin
        lane0Ok = !stall && v0 && (rd0 != '0);
        lane1Ok = !stall && v1 && (rd1 != '0);
        slot1   = count + CW'(lane0Ok);
        total   = slot1 + CW'(lane1Ok);
        cand    = '0;
        cand[DEPTH-1:0] = queue;
        for (int unsigned i = 0; i < DEPTH + 2; i++) begin
            if (lane0Ok && CW'(i) == count) cand[i] = '{valid: 1'b1, rd: rd0, data: d0};
            if (lane1Ok && CW'(i) == slot1) cand[i] = '{valid: 1'b1, rd: rd1, data: d1};
        end
        loadOut   = (total != '0);
        queueNext = cand[DEPTH:1];
        countNext = loadOut ? total - CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queue <= '0;
            count <= '0;
            we    <= 1'b0;
            rw    <= '0;
            inW   <= '0;
        end else begin
            queue <= queueNext;
            count <= countNext;
            we    <= loadOut;
            if (loadOut) begin
                rw  <= cand[0].rd;
                inW <= cand[0].data;
            end
        end
    end

    wb_lookup #(.DEPTH(DEPTH)) lookupA (
        .addr(qa), .outValid(we), .outRd(rw), .outData(inW),
        .entries(queue), .hit(hitA), .data(fwdA)
    );

    wb_lookup #(.DEPTH(DEPTH)) lookupB (
        .addr(qb), .outValid(we), .outRd(rw), .outData(inW),
        .entries(queue), .hit(hitB), .data(fwdB)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: directed lane vectors, negedge monitor checks write order.
module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1;
    logic [4:0]  rd0, rd1, qa, qb, rw;
    logic [31:0] d0, d1, inW, fwdA, fwdB;
    logic        stall, we, hitA, hitB, empty;

    int          checks = 0;
    int          failures = 0;
    int          mcount = 0;
    logic [36:0] sb[$];
    logic [36:0] monExp;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .v0(v0), .rd0(rd0), .d0(d0),
        .v1(v1), .rd1(rd1), .d1(d1),
        .stall(stall), .we(we), .rw(rw), .inW(inW),
        .qa(qa), .qb(qb), .hitA(hitA), .hitB(hitB),
        .fwdA(fwdA), .fwdB(fwdB), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && we) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got rw=%0d inW=%h expected no write", rw, inW);
            end else begin
                monExp = sb.pop_front();
                chk("wb_rw", 32'(rw), 32'(monExp[36:32]));
                chk("wb_inW", inW, monExp[31:0]);
            end
        end
    end

    // Drives one cycle of lanes; the reference model decides acceptance from its own count.
    task automatic issue(input logic a0, input logic [4:0] r0, input logic [31:0] x0,
                         input logic a1, input logic [4:0] r1, input logic [31:0] x1);
        logic mstall;
        v0 = a0; rd0 = r0; d0 = x0;
        v1 = a1; rd1 = r1; d1 = x1;
        mstall = (mcount >= DEPTH - 1);
        chk("stall", 32'(stall), 32'(mstall));
        if (!mstall) begin
            if (a0 && r0 != 0) begin sb.push_back({r0, x0}); mcount++; end
            if (a1 && r1 != 0) begin sb.push_back({r1, x1}); mcount++; end
        end
        @(posedge clk);
        #1;
        if (mcount > 0) mcount--;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (sb.size() != 0 || we); i++) idle();
        chk("drain_pending", 32'(sb.size()), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        v0 = 1'b0; v1 = 1'b0; rd0 = '0; rd1 = '0; d0 = '0; d1 = '0; qa = '0; qb = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_rw", 32'(rw), 32'd0);
        chk("rst_inW", inW, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_hits", {30'd0, hitA, hitB}, 32'd0);
        chk("rst_fwdA", fwdA, 32'd0);
        chk("rst_fwdB", fwdB, 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // single lane, one-cycle latency
        issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        chk("lat_we", 32'(we), 32'd1);
        chk("lat_rw", 32'(rw), 32'd5);
        chk("lat_inW", inW, 32'hDEADBEEF);
        idle();
        chk("lat_we_off", 32'(we), 32'd0);
        chk("lat_empty", 32'(empty), 32'd1);

        // same rd on both lanes; bypass returns the younger value
        issue(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        qa = 5'd3; #1;
        chk("same_hitA", 32'(hitA), 32'd1);
        chk("same_fwdA", fwdA, 32'h22);
        idle();
        chk("same_fwdA_last", fwdA, 32'h22);
        idle();
        chk("same_hitA_gone", 32'(hitA), 32'd0);
        chk("same_fwdA_miss", fwdA, 32'd0);

        // write to $0 discarded
        issue(1'b1, 5'd0, 32'h55, 1'b1, 5'd7, 32'h77);
        qa = 5'd0; #1;
        chk("zero_hitA", 32'(hitA), 32'd0);
        chk("zero_fwdA", fwdA, 32'd0);
        qa = 5'd7; #1;
        chk("r7_hitA", 32'(hitA), 32'd1);
        chk("r7_fwdA", fwdA, 32'h77);
        qa = 5'd0;
        drain();

        // dual-lane stream every cycle: stall throttles, dropped lanes never written
        for (int k = 0; k < 8; k++)
            issue(1'b1, 5'(10 + k), 32'h1000 + 32'(k), 1'b1, 5'(20 + k), 32'h2000 + 32'(k));
        drain();

        // lookup priority: tail entry beats head entry
        issue(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        issue(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
        qb = 5'd9; qa = 5'd2; #1;
        chk("prio_hitB", 32'(hitB), 32'd1);
        chk("prio_fwdB", fwdB, 32'hB);
        chk("prio_outreg_fwdA", fwdA, 32'h2);
        qa = '0; qb = '0;
        drain();

        // reset with three entries pending
        issue(1'b1, 5'd11, 32'h111, 1'b1, 5'd12, 32'h112);
        issue(1'b1, 5'd13, 32'h113, 1'b1, 5'd14, 32'h114);
        issue(1'b1, 5'd15, 32'h115, 1'b1, 5'd16, 32'h116);
        chk("pre_rst_stall", 32'(stall), 32'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        mcount = 0;
        #1;
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        idle();
        idle();
        chk("post_rst_we", 32'(we), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout: got no finish expected finish before 50000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
